// File: rtl/qspi_boot_seq_if.sv
// Signal bundle between the boot sequencer, the exotiny core memory port
// and the SB_IO/QSPI pads. The master side is the sequencer itself.
interface qspi_boot_seq_if;
    // core side
    logic       core_cs_ram_n_i;
    logic       core_cs_rom_n_i;
    logic       core_sck_i;
    logic [3:0] core_sdo_i;
    logic [3:0] core_sdoen_i;
    logic [3:0] core_sdi_o;
    logic       core_rst_no;
    // pad side
    logic       cs_ram_on;
    logic       cs_rom_on;
    logic       sck_o;
    logic [3:0] pad_sdo_o;
    logic [3:0] pad_sdoen_o;
    logic [3:0] pad_sdi_i;
    // status
    logic       done_o;

    modport master (
        input  core_cs_ram_n_i, core_cs_rom_n_i, core_sck_i, core_sdo_i, core_sdoen_i, pad_sdi_i,
        output core_sdi_o, core_rst_no, cs_ram_on, cs_rom_on, sck_o, pad_sdo_o, pad_sdoen_o, done_o
    );

    modport slave (
        output core_cs_ram_n_i, core_cs_rom_n_i, core_sck_i, core_sdo_i, core_sdoen_i, pad_sdi_i,
        input  core_sdi_o, core_rst_no, cs_ram_on, cs_rom_on, sck_o, pad_sdo_o, pad_sdoen_o, done_o
    );
endinterface

// File: rtl/qspi_boot_seq.sv
// QSPI bring-up sequencer: after reset it wakes the flash (ROM command),
// puts the PSRAM into quad mode (RAM command), waits a wake time and then
// hands the shared QSPI bus to the core as a plain pass-through.
module qspi_boot_seq #(
    parameter logic [7:0]  ROM_CMD     = 8'hAB,
    parameter logic [7:0]  RAM_CMD     = 8'h35,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned WAKE_CYCLES = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    qspi_boot_seq_if.master bus
);

    // One counter serves the shift (16 half-bits), the gap and the wake wait.
    localparam int unsigned MAX_A   = (GAP_CYCLES > 16) ? GAP_CYCLES : 16;
    localparam int unsigned MAX_CNT = (WAKE_CYCLES > MAX_A) ? WAKE_CYCLES : MAX_A;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(15);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'((WAKE_CYCLES == 0) ? 0 : WAKE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ROM_SETUP,
        S_ROM_SHIFT,
        S_ROM_HOLD,
        S_GAP,
        S_RAM_SETUP,
        S_RAM_SHIFT,
        S_RAM_HOLD,
        S_WAIT,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       rom_phase;
    logic       shifting;
    logic       cmd_phase;
    logic [7:0] cmd;
    logic [2:0] bit_idx;
    logic       io0;

    // State and counter registers; reset wins from any state.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the case leaves it unassigned (no inferred latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_ROM_SETUP;
                cnt_d   = '0;
            end
            S_ROM_SETUP: begin
                state_d = S_ROM_SHIFT;
                cnt_d   = '0;
            end
            S_ROM_SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    state_d = S_ROM_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ROM_HOLD: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_RAM_SETUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RAM_SETUP: begin
                state_d = S_RAM_SHIFT;
                cnt_d   = '0;
            end
            S_RAM_SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    state_d = S_RAM_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RAM_HOLD: begin
                state_d = (WAKE_CYCLES == 0) ? S_DONE : S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (cnt_q == WAKE_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Serial bit selection: SETUP presents bit 7, SHIFT steps one bit every
    // two cycles so IO0 only changes while sck is low (SPI mode 0).
    always_comb begin
        rom_phase = (state_q == S_ROM_SETUP) || (state_q == S_ROM_SHIFT);
        shifting  = (state_q == S_ROM_SHIFT) || (state_q == S_RAM_SHIFT);
        cmd_phase = rom_phase || (state_q == S_RAM_SETUP) || (state_q == S_RAM_SHIFT);
        cmd       = rom_phase ? ROM_CMD : RAM_CMD;
        bit_idx   = (state_q == S_ROM_SETUP || state_q == S_RAM_SETUP) ? 3'd7
                                                                       : 3'd7 - cnt_q[3:1];
        io0       = cmd_phase ? cmd[bit_idx] : 1'b0;
    end

    // Pad and core-control outputs; only DONE looks at the core inputs.
    always_comb begin
        bus.cs_rom_on   = 1'b1;
        bus.cs_ram_on   = 1'b1;
        bus.sck_o       = 1'b0;
        bus.pad_sdo_o   = 4'b0000;
        bus.pad_sdoen_o = 4'b0000;
        bus.done_o      = 1'b0;
        bus.core_rst_no = 1'b0;
        unique case (state_q)
            S_IDLE: ;
            S_DONE: begin
                bus.cs_ram_on   = bus.core_cs_ram_n_i;
                bus.cs_rom_on   = bus.core_cs_rom_n_i;
                bus.sck_o       = bus.core_sck_i;
                bus.pad_sdo_o   = bus.core_sdo_i;
                bus.pad_sdoen_o = bus.core_sdoen_i;
                bus.done_o      = 1'b1;
                bus.core_rst_no = 1'b1;
            end
            default: begin
                // IO2/IO3 held high keep WP#/HOLD# inactive; IO1 stays an input.
                bus.pad_sdoen_o = 4'b1101;
                bus.pad_sdo_o   = {2'b11, 1'b0, io0};
                bus.sck_o       = shifting & cnt_q[0];
                if (state_q == S_ROM_SETUP || state_q == S_ROM_SHIFT || state_q == S_ROM_HOLD)
                    bus.cs_rom_on = 1'b0;
                if (state_q == S_RAM_SETUP || state_q == S_RAM_SHIFT || state_q == S_RAM_HOLD)
                    bus.cs_ram_on = 1'b0;
            end
        endcase
    end

    // Read data is always routed to the core; it sits in reset until DONE.
    assign bus.core_sdi_o = bus.pad_sdi_i;

endmodule
